// File: rtl/stats_finalize.sv
// Post-accumulation statistics: snapshots sum / sum-of-squares / count, then
// derives mean, mean of squares and variance with one shared bit-serial divider.
module stats_finalize #(
    parameter int W_ACC = 64,
    parameter int W_CNT = 32
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             start,
    input  logic [W_ACC-1:0] sum_in,
    input  logic [W_ACC-1:0] sum_square_in,
    input  logic [W_CNT-1:0] count_in,
    output logic             busy,
    output logic             done,
    output logic [W_ACC-1:0] mean_out,
    output logic [W_ACC-1:0] mean_sq_out,
    output logic [W_ACC-1:0] var_out,
    output logic             err_div0,
    output logic             err_ovf
);
    // state      | meaning
    // S_IDLE     | waiting for start, outputs hold last result
    // S_DIV_MEAN | dividing sum snapshot by N, one quotient bit per cycle
    // S_DIV_SQ   | dividing sum_square snapshot by N
    // S_SQUARE   | low half of mean squared, overflow check on high half
    // S_SUB      | variance = mean_sq - mean^2, underflow check
    // S_FINISH   | load outputs, pulse done
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_DIV_MEAN = 3'd1;
    localparam logic [2:0] S_DIV_SQ   = 3'd2;
    localparam logic [2:0] S_SQUARE   = 3'd3;
    localparam logic [2:0] S_SUB      = 3'd4;
    localparam logic [2:0] S_FINISH   = 3'd5;

    localparam int W_HALF = W_ACC / 2;
    localparam int W_BC   = $clog2(W_ACC);
    localparam logic [W_BC-1:0] BC_LAST = W_BC'(W_ACC - 1);

    logic [2:0]       state;
    logic [W_BC-1:0]  bit_cnt;
    logic [W_ACC-1:0] quo_sh;
    logic [W_CNT-1:0] rem;
    logic [W_ACC-1:0] sq_snap;
    logic [W_CNT-1:0] cnt_snap;
    logic [W_ACC-1:0] mean_q;
    logic [W_ACC-1:0] sq_q;
    logic [W_ACC-1:0] var_q;
    logic             ovf_pend;
    logic             div0_pend;

    logic [W_CNT:0]   trial;
    logic             fits;
    logic [W_CNT-1:0] rem_next;
    logic [W_ACC-1:0] quo_next;
    logic [W_ACC-1:0] mean_ext;

    // Remainder stays below N, so only the trial value needs the extra bit.
    always_comb begin
        trial    = {rem, quo_sh[W_ACC-1]};
        fits     = (trial >= {1'b0, cnt_snap});
        rem_next = fits ? W_CNT'(trial - {1'b0, cnt_snap}) : trial[W_CNT-1:0];
        quo_next = {quo_sh[W_ACC-2:0], fits};
        mean_ext = {{(W_ACC - W_HALF){1'b0}}, mean_q[W_HALF-1:0]};
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            quo_sh      <= '0;
            rem         <= '0;
            sq_snap     <= '0;
            cnt_snap    <= '0;
            mean_q      <= '0;
            sq_q        <= '0;
            var_q       <= '0;
            ovf_pend    <= 1'b0;
            div0_pend   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mean_out    <= '0;
            mean_sq_out <= '0;
            var_out     <= '0;
            err_div0    <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        quo_sh   <= sum_in;
                        sq_snap  <= sum_square_in;
                        cnt_snap <= count_in;
                        rem      <= '0;
                        bit_cnt  <= BC_LAST;
                        ovf_pend <= 1'b0;
                        busy     <= 1'b1;
                        if (count_in == '0) begin
                            div0_pend <= 1'b1;
                            state     <= S_FINISH;
                        end else begin
                            div0_pend <= 1'b0;
                            state     <= S_DIV_MEAN;
                        end
                    end
                end
                S_DIV_MEAN: begin
                    bit_cnt <= bit_cnt - 1'b1;
                    if (bit_cnt == '0) begin
                        mean_q  <= quo_next;
                        quo_sh  <= sq_snap;
                        rem     <= '0;
                        bit_cnt <= BC_LAST;
                        state   <= S_DIV_SQ;
                    end else begin
                        quo_sh <= quo_next;
                        rem    <= rem_next;
                    end
                end
                S_DIV_SQ: begin
                    bit_cnt <= bit_cnt - 1'b1;
                    quo_sh  <= quo_next;
                    rem     <= rem_next;
                    if (bit_cnt == '0) begin
                        sq_q  <= quo_next;
                        state <= S_SQUARE;
                    end
                end
                S_SQUARE: begin
                    var_q    <= mean_ext * mean_ext;
                    ovf_pend <= |mean_q[W_ACC-1:W_HALF];
                    state    <= S_SUB;
                end
                S_SUB: begin
                    var_q    <= sq_q - var_q;
                    ovf_pend <= ovf_pend | (sq_q < var_q);
                    state    <= S_FINISH;
                end
                S_FINISH: begin
                    if (div0_pend) begin
                        mean_out    <= '0;
                        mean_sq_out <= '0;
                        var_out     <= '0;
                        err_div0    <= 1'b1;
                        err_ovf     <= 1'b0;
                    end else begin
                        mean_out    <= mean_q;
                        mean_sq_out <= sq_q;
                        var_out     <= var_q;
                        err_div0    <= 1'b0;
                        err_ovf     <= ovf_pend;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stats_finalize.sv
// Randomized self-checking bench for stats_finalize against an arithmetic model.
module tb_stats_finalize;
    logic        clk = 1'b0;
    logic        nreset;
    logic        start;
    logic [63:0] sum_in;
    logic [63:0] sum_square_in;
    logic [31:0] count_in;
    logic        busy;
    logic        done;
    logic [63:0] mean_out;
    logic [63:0] mean_sq_out;
    logic [63:0] var_out;
    logic        err_div0;
    logic        err_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    stats_finalize #(.W_ACC(64), .W_CNT(32)) dut (
        .clk(clk), .nreset(nreset), .start(start),
        .sum_in(sum_in), .sum_square_in(sum_square_in), .count_in(count_in),
        .busy(busy), .done(done), .mean_out(mean_out), .mean_sq_out(mean_sq_out),
        .var_out(var_out), .err_div0(err_div0), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [63:0] s, input logic [63:0] sq, input logic [31:0] n,
                                  output logic [63:0] m, output logic [63:0] msq,
                                  output logic [63:0] v, output logic d0, output logic ov);
        logic [63:0] lo;
        logic [63:0] p;
        if (n == 0) begin
            m = 0; msq = 0; v = 0; d0 = 1'b1; ov = 1'b0;
        end else begin
            m   = s / 64'(n);
            msq = sq / 64'(n);
            lo  = m & 64'hFFFF_FFFF;
            p   = lo * lo;
            v   = msq - p;
            d0  = 1'b0;
            ov  = (m >= 64'h1_0000_0000) || (msq < p);
        end
    endfunction

    // Caller must be just after a rising edge; start is sampled at the next edge.
    task automatic run_op(input logic [63:0] s, input logic [63:0] sq, input logic [31:0] n,
                          input bit glitch);
        logic [63:0] em, emsq, ev;
        logic        ed0, eov;
        int          lat;
        model(s, sq, n, em, emsq, ev, ed0, eov);
        sum_in = s; sum_square_in = sq; count_in = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_val("busy_after_start", busy, 1);
        check_val("done_low_at_start", done, 0);
        lat = 0;
        for (int k = 1; k <= 300; k++) begin
            if (glitch && (k == 10 || k == 100)) begin
                start = 1'b1;
                sum_in = {$urandom, $urandom};
                sum_square_in = {$urandom, $urandom};
                count_in = $urandom_range(1, 100);
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
        check_val("latency", 64'(lat), (n == 0) ? 64'd1 : 64'd131);
        check_val("busy_at_done", busy, 0);
        check_val("mean", mean_out, em);
        check_val("mean_sq", mean_sq_out, emsq);
        if (em < 64'h1_0000_0000) check_val("var", var_out, ev);
        check_val("err_div0", err_div0, ed0);
        check_val("err_ovf", err_ovf, eov);
    endtask

    initial begin
        logic [63:0] s, sq, x;
        logic [31:0] n;
        bit          seen_done;
        nreset = 1'b0; start = 1'b0;
        sum_in = 0; sum_square_in = 0; count_in = 0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_mean", mean_out, 0);
        check_val("rst_var", var_out, 0);
        check_val("rst_err_div0", err_div0, 0);
        nreset = 1'b1;
        @(posedge clk); #1;

        run_op(64'd10, 64'd30, 32'd4, 1'b0);
        run_op(64'd65535000, 64'd4294836225000, 32'd1000, 1'b0);
        run_op(64'd12345, 64'd999, 32'd0, 1'b0);
        run_op(64'd1 << 40, 64'd0, 32'd1, 1'b0);
        run_op(64'd10, 64'd30, 32'd4, 1'b1);
        run_op(64'd65535000, 64'd4294836225000, 32'd1000, 1'b0);

        // Reset at edge 50 of a computation, with start also high at that edge.
        sum_in = 64'd500; sum_square_in = 64'd9000; count_in = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        nreset = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; nreset = 1'b1;
        check_val("abort_busy", busy, 0);
        check_val("abort_done", done, 0);
        check_val("abort_mean", mean_out, 0);
        check_val("abort_mean_sq", mean_sq_out, 0);
        seen_done = 1'b0;
        repeat (200) begin
            @(posedge clk); #1;
            if (done || busy) seen_done = 1'b1;
        end
        check_val("abort_no_done", 64'(seen_done), 0);
        run_op(64'd500, 64'd9000, 32'd7, 1'b0);

        // Consistent streams of 16-bit samples.
        for (int t = 0; t < 12; t++) begin
            n = $urandom_range(1, 200);
            s = 0; sq = 0;
            for (int i = 0; i < int'(n); i++) begin
                x = 64'($urandom_range(0, 65535));
                s += x;
                sq += x * x;
            end
            run_op(s, sq, n, t[0]);
        end

        // Arbitrary operands stress the divider and error paths.
        for (int t = 0; t < 12; t++) begin
            s  = {$urandom, $urandom};
            sq = {$urandom, $urandom};
            case (t % 4)
                0: n = $urandom;
                1: n = $urandom_range(1, 3);
                2: n = 32'hFFFF_FFFF;
                default: n = $urandom_range(0, 1);
            endcase
            run_op(s, sq, n, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/stats_finalize.md
# stats_finalize

Post-accumulation statistics stage. It sits directly downstream of the sum / sum-of-squares accumulator. On a `start` strobe it snapshots the accumulated `sum`, `sum_square` and sample count. It then computes, with a bit-serial divider, the integer mean, mean of squares and variance of the unsigned 16-bit sample stream, and presents registered results with a one-cycle `done` pulse.

## Interface
Parameters:
- `W_ACC`, 64: width of the accumulator inputs and of the quotients.
- `W_CNT`, 32: width of the sample count.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `nreset`  in  1  reset, synchronous and active-low.
- `start`  in  1  request; sampled only while `busy`=0.
- `sum_in`  in  W_ACC  accumulated sum of samples.
- `sum_square_in`  in  W_ACC  accumulated sum of squared samples.
- `count_in`  in  W_CNT  number of samples accumulated.
- `busy`  out  1  computation in progress.
- `done`  out  1  one-cycle pulse; results valid.
- `mean_out`  out  W_ACC  floor(sum/N).
- `mean_sq_out`  out  W_ACC  floor(sum_square/N).
- `var_out`  out  W_ACC  mean_sq_out − mean_out², modulo 2^W_ACC.
- `err_div0`  out  1  N was 0.
- `err_ovf`  out  1  mean_out[63:32]≠0, or the subtraction underflowed.

## Operation
- States: IDLE, DIV_MEAN, DIV_SQ, SQUARE, SUB, FINISH.
- **IDLE:**
  - On `start`=1, snapshot `sum_in`, `sum_square_in` and `count_in` into internal registers.
  - Assert `busy`.
  - Go to DIV_MEAN, or to FINISH with `err_div0` pending if `count_in`=0.
  - Inputs are not observed again until the next accepted start, so upstream may clear or keep accumulating.
- **DIV_MEAN:** restoring division of the sum snapshot by N.
  - One quotient bit per cycle, MSB first, over exactly 64 cycles.
  - Partial remainder is W_CNT+1 bits; the quotient is W_ACC bits.
- **DIV_SQ:** same divider, reused on the sum_square snapshot, 64 cycles.
- **SQUARE:**
  - product = mean_q[31:0] × mean_q[31:0], 64-bit unsigned.
  - Flag overflow if mean_q[63:32]≠0.
- **SUB:**
  - var = sq_q − product, modulo 2^64.
  - Flag overflow if sq_q < product.
- **FINISH:**
  - Load all output registers and error flags.
  - Pulse `done`, drop `busy`, return to IDLE.
- Outputs hold their values until the next FINISH or reset.
- `start` while `busy`=1 is ignored, neither queued nor latched.
- For consistent inputs from 16-bit unsigned samples: mean ≤ 65535, var ≥ 0, `err_ovf`=0.
- On the div-by-zero path, FINISH loads `mean_out`, `mean_sq_out` and `var_out` as 0, `err_div0`=1, `err_ovf`=0.

## Timing
- Edge 0 is the rising edge at which `start`=1 is sampled in IDLE. `busy`=1 after edge 0.
- **Normal path:**
  - Edges 1–64: DIV_MEAN.
  - Edges 65–128: DIV_SQ.
  - Edge 129: SQUARE.
  - Edge 130: SUB.
  - Edge 131: FINISH. Outputs update, `done`=1 and `busy`=0 after edge 131; `done`=0 after edge 132.
  - Fixed latency is 131 cycles regardless of operand values.
- **N=0 path:** FINISH at edge 1; `done`=1 after edge 1.
- A new `start` is accepted at the edge following the `done` rise (back-to-back allowed), e.g. edge 132.
- **Reset** (`nreset`=0 at an edge): state becomes IDLE.
  - Values after that edge: `busy`=0, `done`=0, all outputs and flags 0, internal snapshot cleared.
  - Reset mid-computation aborts with no `done`.
  - A `start` at the reset edge is ignored.
- Reset value of every output: 0.

## Test plan
- sum=10, sum_square=30, N=4 (samples 1..4) → at edge 131: `done`=1, mean_out=2, mean_sq_out=7, var_out=3, both error flags 0.
- Constant sample 65535, N=1000: sum=65535000, sum_square=4294836225000 → mean_out=65535, mean_sq_out=4294836225, var_out=0.
- N=0, any sum → `done` after edge 1; mean_out=mean_sq_out=var_out=0, `err_div0`=1.
- sum=2^40, sum_square=0, N=1 → mean_out=2^40, `err_ovf`=1, `done` at edge 131.
- Start accepted; re-assert `start` at edges 10 and 100 with different inputs → ignored, results match the first snapshot. Then `start` at edge 132 → second `done` at edge 263.
- Start, then `nreset`=0 at edge 50 → `busy`=0 after edge 50; no `done` ever; outputs 0. A fresh start afterwards completes normally in 131 cycles.
